// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit BCD display scanner with frame-synchronous data commit and leading-zero blanking.
// Outputs registered, 1-cycle; loads never stall, the latest pending value wins at each frame wrap.
module seven_segment_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    output logic [3:0]  BCD,
    output logic        DP,
    output logic [3:0]  AN,
    output logic        frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_disp_dig;
    logic [3:0]    r_disp_dp;
    logic [15:0]   r_pend_dig;
    logic [3:0]    r_pend_dp;
    logic          r_pend;

    logic          w_tick;
    logic          w_wrap;
    logic          w_commit;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_dig_nxt;
    logic [3:0]    w_dp_nxt;
    logic [3:0]    w_nib;
    logic          w_upper_zero;
    logic          w_blank;
    logic [3:0]    w_an;

    // Outputs are computed from next-cycle idx/display so they change on the same edge idx does.
    always_comb begin
        w_tick    = (r_presc == LAST);
        w_wrap    = w_tick && (r_idx == 2'd3);
        w_commit  = w_wrap && r_pend;
        w_idx_nxt = r_idx + {1'b0, w_tick};
        w_dig_nxt = w_commit ? r_pend_dig : r_disp_dig;
        w_dp_nxt  = w_commit ? r_pend_dp  : r_disp_dp;
        w_nib     = w_dig_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_upper_zero = 1'b0;
        case (w_idx_nxt)
            2'd3:    w_upper_zero = (w_dig_nxt[15:12] == 4'h0);
            2'd2:    w_upper_zero = (w_dig_nxt[15:8]  == 8'h00);
            2'd1:    w_upper_zero = (w_dig_nxt[15:4]  == 12'h000);
            default: w_upper_zero = 1'b0;
        endcase
        w_blank = (BLANK_LZ != 0) && w_upper_zero && !w_dp_nxt[w_idx_nxt];
        w_an    = w_blank ? 4'b0000 : (4'b0001 << w_idx_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_idx      <= 2'd0;
            r_disp_dig <= 16'h0000;
            r_disp_dp  <= 4'h0;
            r_pend_dig <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_pend     <= 1'b0;
            BCD        <= 4'h0;
            DP         <= 1'b0;
            AN         <= 4'b0001;
            frame_done <= 1'b0;
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + 1'b1;
            r_idx      <= w_idx_nxt;
            r_disp_dig <= w_dig_nxt;
            r_disp_dp  <= w_dp_nxt;
            // A load on the wrap edge keeps pending set for the value just captured.
            if (load) begin
                r_pend_dig <= digits;
                r_pend_dp  <= dp_in;
                r_pend     <= 1'b1;
            end else if (w_commit) begin
                r_pend     <= 1'b0;
            end
            BCD        <= w_nib;
            DP         <= w_dp_nxt[w_idx_nxt];
            AN         <= w_an;
            frame_done <= w_wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized and directed bench for seven_segment_scanner against an edge-count based reference model.
`timescale 1ns/1ps
module tb_seven_segment_scanner;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  BCD, BCD2;
    logic        DP, DP2;
    logic [3:0]  AN, AN2;
    logic        frame_done, fd2;

    seven_segment_scanner #(.SCAN_DIV(N), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp_in(dp_in),
        .BCD(BCD), .DP(DP), .AN(AN), .frame_done(frame_done)
    );

    seven_segment_scanner #(.SCAN_DIV(N), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .dp_in(dp_in),
        .BCD(BCD2), .DP(DP2), .AN(AN2), .frame_done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          e;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    bit          m_pv, m_fd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", tag, obs, exp, e, $time);
        end
    endtask

    task automatic model_reset();
        e = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0; m_pv = 0; m_fd = 0;
    endtask

    // Slot is pure arithmetic on edges since release; frame wraps every 4*N edges.
    task automatic model_edge(input bit ld, input logic [15:0] d, input logic [3:0] dp);
        e++;
        m_fd = (e % (4 * N) == 0);
        if (m_fd && m_pv) begin
            m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 0;
        end
        if (ld) begin
            m_pend = d; m_pend_dp = dp; m_pv = 1;
        end
    endtask

    task automatic check_all();
        int          slot;
        logic [15:0] upper;
        logic [3:0]  ean, ean_nb;
        logic        edp;
        slot   = (e / N) % 4;
        upper  = m_disp >> (4 * slot);
        edp    = m_disp_dp[slot];
        ean_nb = 4'(1 << slot);
        ean    = (slot != 0 && upper == 16'h0 && !edp) ? 4'b0000 : ean_nb;
        chk("BCD", {12'h0, BCD}, upper & 16'h000F);
        chk("DP", {15'h0, DP}, {15'h0, edp});
        chk("AN", {12'h0, AN}, {12'h0, ean});
        chk("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
        chk("AN_noblank", {12'h0, AN2}, {12'h0, ean_nb});
    endtask

    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dp);
        load = ld; digits = d; dp_in = dp;
        @(posedge clk);
        model_edge(ld, d, dp);
        #1;
        check_all();
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic step_to_wrap(input logic [15:0] d, input logic [3:0] dp);
        while ((e + 1) % (4 * N) != 0) step(1'b0, 16'h0, 4'h0);
        step(1'b1, d, dp);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic [3:0]  dp;
        rst_n = 1'b0; load = 1'b0; digits = '0; dp_in = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        idle(17);
        step(1'b1, 16'h1234, 4'b0000); idle(32);
        step(1'b1, 16'h0050, 4'b0100); idle(32);
        step(1'b1, 16'h1111, 4'b0000); idle(2);
        step(1'b1, 16'h2222, 4'b0000); idle(32);
        step(1'b1, 16'h00A0, 4'b0000); idle(32);
        step(1'b1, 16'h0987, 4'b0010); step_to_wrap(16'h4005, 4'b1000); idle(40);
        step(1'b1, 16'h3333, 4'b0000); idle(2);
        do_reset();
        idle(40);

        for (int c = 0; c < 600; c++) begin
            d = '0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) != 0) d[4*k +: 4] = 4'($urandom_range(0, 15));
            dp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step($urandom_range(0, 4) == 0, d, dp);
            if (c == 300) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
